vend_fsm_param: RTL and testbench

- Parametrised coin-operated vending controller for nickel, dime and quarter coins.
- Accumulates credit in cents in a binary register and asserts a one-cycle vend pulse once credit reaches PRICE.
- Returns change or a cancel refund as a sequence of individual coins, using a valid/ready handshake to the coin dispenser.
- Sits between the coin acceptor front end and the product/coin dispenser drivers.

---
 rtl/vend_fsm_param_if.sv | 22 ++
 rtl/vend_fsm_param.sv | 75 +++++++
 tb/tb_vend_fsm_param.sv | 115 +++++++++++
 3 files changed

// File: rtl/vend_fsm_param_if.sv
// vend_fsm_param_if: coin acceptor, product dispenser and change dispenser signals of the vending controller.
interface vend_fsm_param_if #(
   parameter int CREDIT_W = 7
);
   logic [1:0]          coin;
   logic                cancel;
   logic                change_ready;
   logic                vend;
   logic                change_valid;
   logic [1:0]          change_coin;
   logic                coin_reject;
   logic [CREDIT_W-1:0] credit;
   logic [1:0]          state;
   modport master (
      output coin, cancel, change_ready,
      input  vend, change_valid, change_coin, coin_reject, credit, state
   );
   modport slave (
      input  coin, cancel, change_ready,
      output vend, change_valid, change_coin, coin_reject, credit, state
   );
endinterface

// File: rtl/vend_fsm_param.sv
// vend_fsm_param: coin vending controller with binary credit, one-cycle vend pulse
// and greedy coin-by-coin change/refund over a valid/ready handshake.
module vend_fsm_param #(
   parameter int CREDIT_W   = 7,
   parameter int PRICE      = 25,
   parameter int MAX_CREDIT = 100
) (
   input logic              clock,
   input logic              reset,
   vend_fsm_param_if.slave  bus
);
   localparam logic [1:0] IDLE    = 2'b00;
   localparam logic [1:0] COLLECT = 2'b01;
   localparam logic [1:0] VEND    = 2'b10;
   localparam logic [1:0] CHANGE  = 2'b11;
   localparam int W = CREDIT_W + 1;
   logic [1:0]          state_q, state_nx;
   logic [CREDIT_W-1:0] credit_q, credit_nx;
   logic [W-1:0]        coin_val, sum;
   logic                take, accept, reject_nx;
   logic [CREDIT_W-1:0] denom, left_vend, left_change;
   logic [1:0]          code_nx;
   logic                vend_q, valid_q, reject_q;
   logic [1:0]          coin_q;
   // sum is one bit wider than credit so the MAX_CREDIT compare cannot wrap
   always_comb begin
      coin_val    = bus.coin == 2'b01 ? W'(5) : bus.coin == 2'b10 ? W'(10) : bus.coin == 2'b11 ? W'(25) : '0;
      sum         = {1'b0, credit_q} + coin_val;
      take        = bus.coin != 2'b00 && (state_q == IDLE || (state_q == COLLECT && !bus.cancel));
      accept      = take && sum <= W'(MAX_CREDIT);
      reject_nx   = bus.coin != 2'b00 && !accept;
      denom       = credit_q >= CREDIT_W'(25) ? CREDIT_W'(25) : credit_q >= CREDIT_W'(10) ? CREDIT_W'(10) : CREDIT_W'(5);
      left_vend   = credit_q - CREDIT_W'(PRICE);
      left_change = credit_q - denom;
      state_nx    = state_q;
      credit_nx   = credit_q;
      if (accept) begin
         credit_nx = sum[CREDIT_W-1:0];
         state_nx  = sum >= W'(PRICE) ? VEND : COLLECT;
      end else if (state_q == COLLECT && bus.cancel) begin
         state_nx = CHANGE;
      end else if (state_q == VEND) begin
         credit_nx = left_vend;
         state_nx  = left_vend == '0 ? IDLE : CHANGE;
      end else if (state_q == CHANGE && bus.change_ready) begin
         credit_nx = left_change;
         state_nx  = left_change == '0 ? IDLE : CHANGE;
      end
      code_nx = credit_nx >= CREDIT_W'(25) ? 2'b11 : credit_nx >= CREDIT_W'(10) ? 2'b10 : 2'b01;
   end
   // outputs are registered from the next-state values so they align with state
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= IDLE;
         credit_q <= '0;
         vend_q   <= 1'b0;
         valid_q  <= 1'b0;
         coin_q   <= 2'b00;
         reject_q <= 1'b0;
      end else begin
         state_q  <= state_nx;
         credit_q <= credit_nx;
         vend_q   <= state_nx == VEND;
         valid_q  <= state_nx == CHANGE;
         coin_q   <= state_nx == CHANGE ? code_nx : 2'b00;
         reject_q <= reject_nx;
      end
   end
   assign bus.state        = state_q;
   assign bus.credit       = credit_q;
   assign bus.vend         = vend_q;
   assign bus.change_valid = valid_q;
   assign bus.change_coin  = coin_q;
   assign bus.coin_reject  = reject_q;
endmodule

// File: tb/tb_vend_fsm_param.sv
// tb_vend_fsm_param: directed vectors on a default instance and a PRICE=100 instance.
module tb_vend_fsm_param;
   logic clock = 1'b0;
   logic ra = 1'b1;
   logic rb = 1'b1;
   int   checks = 0;
   int   errors = 0;
   vend_fsm_param_if #(.CREDIT_W(7)) ia ();
   vend_fsm_param_if #(.CREDIT_W(7)) ib ();
   vend_fsm_param #(.CREDIT_W(7), .PRICE(25), .MAX_CREDIT(100)) dut_a (.clock(clock), .reset(ra), .bus(ia));
   vend_fsm_param #(.CREDIT_W(7), .PRICE(100), .MAX_CREDIT(100)) dut_b (.clock(clock), .reset(rb), .bus(ib));
   always #5 clock = ~clock;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask
   task automatic tick();
      @(posedge clock);
      #1;
   endtask
   task automatic expect_out(input string tag, input bit on_b, input int st, input int cr,
                             input int vd, input int cv, input int cc, input int rj);
      chk({tag, ".state"},  on_b ? 32'(ib.state)        : 32'(ia.state),        32'(st));
      chk({tag, ".credit"}, on_b ? 32'(ib.credit)       : 32'(ia.credit),       32'(cr));
      chk({tag, ".vend"},   on_b ? 32'(ib.vend)         : 32'(ia.vend),         32'(vd));
      chk({tag, ".cvalid"}, on_b ? 32'(ib.change_valid) : 32'(ia.change_valid), 32'(cv));
      chk({tag, ".ccoin"},  on_b ? 32'(ib.change_coin)  : 32'(ia.change_coin),  32'(cc));
      chk({tag, ".reject"}, on_b ? 32'(ib.coin_reject)  : 32'(ia.coin_reject),  32'(rj));
   endtask
   task automatic coin_a(input logic [1:0] c);
      ia.coin = c;
      tick();
      ia.coin = 2'b00;
   endtask
   task automatic coin_b(input logic [1:0] c);
      ib.coin = c;
      tick();
      ib.coin = 2'b00;
   endtask
   initial begin
      ia.coin = 2'b00; ia.cancel = 1'b0; ia.change_ready = 1'b1;
      ib.coin = 2'b00; ib.cancel = 1'b0; ib.change_ready = 1'b1;
      tick(); tick();
      ra = 1'b0; rb = 1'b0;
      expect_out("rst_a", 0, 0, 0, 0, 0, 0, 0);
      expect_out("rst_b", 1, 0, 0, 0, 0, 0, 0);
      // exact price: nickel, dime, dime
      coin_a(2'b01); expect_out("t1_n", 0, 1, 5, 0, 0, 0, 0);
      coin_a(2'b10); expect_out("t1_d1", 0, 1, 15, 0, 0, 0, 0);
      coin_a(2'b10); expect_out("t1_vend", 0, 2, 25, 1, 0, 0, 0);
      tick();        expect_out("t1_idle", 0, 0, 0, 0, 0, 0, 0);
      // 45 cents: vend then two dimes of change
      coin_a(2'b01); coin_a(2'b10); coin_a(2'b01);
      expect_out("t2_20", 0, 1, 20, 0, 0, 0, 0);
      coin_a(2'b11); expect_out("t2_vend", 0, 2, 45, 1, 0, 0, 0);
      tick();        expect_out("t2_ch1", 0, 3, 20, 0, 1, 2, 0);
      tick();        expect_out("t2_ch2", 0, 3, 10, 0, 1, 2, 0);
      tick();        expect_out("t2_idle", 0, 0, 0, 0, 0, 0, 0);
      // cancel refund of 15
      coin_a(2'b10); coin_a(2'b01);
      ia.cancel = 1'b1; tick(); ia.cancel = 1'b0;
      expect_out("t3_ch1", 0, 3, 15, 0, 1, 2, 0);
      tick();        expect_out("t3_ch2", 0, 3, 5, 0, 1, 1, 0);
      tick();        expect_out("t3_idle", 0, 0, 0, 0, 0, 0, 0);
      // dispenser stall for 5 cycles
      ia.change_ready = 1'b0;
      coin_a(2'b10); coin_a(2'b10); coin_a(2'b11);
      expect_out("t4_vend", 0, 2, 45, 1, 0, 0, 0);
      for (int i = 0; i < 5; i++) begin
         tick();
         expect_out($sformatf("t4_stall%0d", i), 0, 3, 20, 0, 1, 2, 0);
      end
      ia.change_ready = 1'b1;
      tick();        expect_out("t4_ch1", 0, 3, 10, 0, 1, 2, 0);
      tick();        expect_out("t4_idle", 0, 0, 0, 0, 0, 0, 0);
      // rejected coins during VEND, CHANGE, and cancel+coin in COLLECT
      coin_a(2'b10); coin_a(2'b10); coin_a(2'b11);
      ia.change_ready = 1'b0;
      coin_a(2'b11); expect_out("t5_rvend", 0, 3, 20, 0, 1, 2, 1);
      coin_a(2'b11); expect_out("t5_rchg", 0, 3, 20, 0, 1, 2, 1);
      ia.change_ready = 1'b1;
      tick();        expect_out("t5_ch", 0, 3, 10, 0, 1, 2, 0);
      tick();        expect_out("t5_idle", 0, 0, 0, 0, 0, 0, 0);
      coin_a(2'b01);
      ia.cancel = 1'b1; coin_a(2'b01); ia.cancel = 1'b0;
      expect_out("t5_rcan", 0, 3, 5, 0, 1, 1, 1);
      tick();        expect_out("t5_idle2", 0, 0, 0, 0, 0, 0, 0);
      // cancel is ignored in IDLE, coin accepted
      ia.cancel = 1'b1; coin_a(2'b10); ia.cancel = 1'b0;
      expect_out("t5_idlecan", 0, 1, 10, 0, 0, 0, 0);
      ia.cancel = 1'b1; tick(); ia.cancel = 1'b0;
      tick();        expect_out("t5_idle3", 0, 0, 0, 0, 0, 0, 0);
      // PRICE=100 instance: exact 100 vends
      coin_b(2'b11); coin_b(2'b11); coin_b(2'b11);
      expect_out("t6_75", 1, 1, 75, 0, 0, 0, 0);
      coin_b(2'b11); expect_out("t6_vend", 1, 2, 100, 1, 0, 0, 0);
      tick();        expect_out("t6_idle", 1, 0, 0, 0, 0, 0, 0);
      // overflow reject at 95
      coin_b(2'b11); coin_b(2'b11); coin_b(2'b11); coin_b(2'b10);
      expect_out("t6_85", 1, 1, 85, 0, 0, 0, 0);
      coin_b(2'b10); expect_out("t6_95", 1, 1, 95, 0, 0, 0, 0);
      coin_b(2'b11); expect_out("t6_ovf", 1, 1, 95, 0, 0, 0, 1);
      ib.cancel = 1'b1; tick(); ib.cancel = 1'b0;
      expect_out("t6_ch1", 1, 3, 95, 0, 1, 3, 0);
      tick();        expect_out("t6_ch2", 1, 3, 70, 0, 1, 3, 0);
      tick();        expect_out("t6_ch3", 1, 3, 45, 0, 1, 3, 0);
      rb = 1'b1; tick(); rb = 1'b0;
      expect_out("t6_rst", 1, 0, 0, 0, 0, 0, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
